booth_mul_issue: RTL
====================

Name: booth_mul_issue

Overview:
- Upstream issue/sequencer stage for the 32x32 radix-2 Booth multiplier. It queues operand pairs through a valid/ready handshake and issues one multiply at a time with a single-cycle start pulse.
- It holds the operands stable for the whole iterative multiply, captures the 64-bit product on the multiplier's one-cycle valid pulse, and presents it, tagged, on a valid/ready result port.

Parameters:
- DEPTH, 4, operand FIFO entries; power of two, >=2.
- TAG_W, 4, width of the caller-supplied transaction tag.
- TIMEOUT, 64, cycles allowed in WAIT before error; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  FIFO can accept; equals !full.
- in_x  in  32  multiplier operand, signed two's complement.
- in_y  in  32  multiplicand operand, signed two's complement.
- in_tag  in  TAG_W  transaction tag.
- mul_start  out  1  one-cycle start pulse to the multiplier.
- mul_x  out  32  multiplier operand, held stable from ISSUE until capture.
- mul_y  out  32  multiplicand operand, held stable from ISSUE until capture.
- mul_result  in  64  product from the multiplier.
- mul_valid  in  1  one-cycle product-valid pulse.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  64  signed product.
- res_tag  out  TAG_W  tag of the product.
- busy  out  1  high whenever state != IDLE or the FIFO is non-empty.

Behaviour:
- Reset (reset==0 at a clk edge):
  - FIFO flushed; state IDLE.
  - mul_start=0, mul_x=0, mul_y=0, res_valid=0, res_data=0, res_tag=0, busy=0.
  - in_ready=1 from the first cycle after reset.
- Push: in_valid&&in_ready at an edge writes {tag,x,y}.
  - in_ready depends only on full, never on a same-cycle pop. A push while full is impossible by construction.
- FSM states: IDLE, ISSUE, WAIT, OUT.
  - IDLE: if FIFO non-empty, pop the head into the operand registers (mul_x, mul_y, op_tag) and go to ISSUE; otherwise stay.
  - ISSUE: mul_start=1 for exactly this cycle; next WAIT. mul_start is a decode of the state register, so it is never high for two consecutive cycles.
  - WAIT: on mul_valid, register res_data<=mul_result and res_tag<=op_tag, then go to OUT. mul_valid is a single-cycle pulse and must be sampled the cycle it occurs.
  - OUT: res_valid=1, with res_data and res_tag stable until res_ready.
    - On res_valid&&res_ready: if FIFO non-empty, pop and go straight to ISSUE (no IDLE bubble); else go to IDLE.
- Operand stability: mul_x and mul_y change only on a pop, so they are stable from ISSUE through the capture edge.
- Latency from a push into an empty, idle block:
  - push edge T, pop T+1, mul_start high during T+1..T+2, product valid ~33 cycles after start, res_valid the cycle after mul_valid.
- mul_valid outside WAIT is ignored.
- Simultaneous push and pop in the same cycle are both performed; count is unchanged.
- Pointers wrap modulo DEPTH. Count is log2(DEPTH)+1 bits; full when count==DEPTH, empty when count==0.
- Reset mid-operation: everything is cleared regardless of state. The multiplier shares the same system reset. Any late mul_valid then arrives in IDLE and is ignored.
- Results are strictly in push order; there is only one multiply in flight.

Optional Feature:
- Macro: BOOTH_ISSUE_TIMEOUT_EN.
- Enabled:
  - Adds output err (1 bit, reset 0) and a WAIT-cycle counter.
  - If WAIT lasts TIMEOUT cycles without mul_valid, set err (sticky until reset) and go to OUT with res_data=0 and the original tag.
- Disabled: no counter, no err port; WAIT waits indefinitely.

Decomposition:
- Shared package booth_pkg:
  - State encoding typedef (IDLE/ISSUE/WAIT/OUT).
  - Constants OP_W=32 and PROD_W=64.
  - Operand-entry struct {tag, x, y}, shared with the multiplier-side wrappers.
- One sub-module: booth_op_fifo, a synchronous FIFO with DEPTH/width parameters and full/empty/count outputs. The FSM and operand/result registers stay in the top.

Test Plan:
- Basic: push x=3, y=5, tag=1 with res_ready=1 and a model multiplier. Expect exactly one mul_start pulse, then res_data=64'd15 and res_tag=1 for one cycle.
- Signed: x=32'hFFFFFFFE (-2), y=7, tag=2. Expect res_data=64'hFFFFFFFFFFFFFFF2.
- Backpressure:
  - With res_ready=0 and DEPTH=4, offer 6 pushes. 5 are accepted (1 in flight, 4 queued) and in_ready drops to 0.
  - Then release res_ready. Expect 5 results in tag order, with ISSUE following OUT with no IDLE cycle between them.
- Stability: check mul_x/mul_y are unchanged on every cycle from ISSUE to capture. Check a mul_valid injected while in IDLE produces no result.
- Reset mid-WAIT: drive reset=0 for one edge during WAIT.
  - Expect res_valid=0, busy=0, in_ready=1 next cycle.
  - A later stale mul_valid produces no output.
- Timeout (BOOTH_ISSUE_TIMEOUT_EN, TIMEOUT=64): the model never asserts mul_valid. Expect err=1 after 64 WAIT cycles and res_valid with res_data=0 and the original tag.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types and widths for the Booth multiplier issue stage and its wrappers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package booth_pkg;

  localparam int OP_W   = 32;
  localparam int PROD_W = 64;

  // Sequencer state: one multiply in flight at a time.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  // Operand pair as queued and presented to the multiplier. The tag width is a
  // per-instance parameter, so it is carried alongside this struct.
  typedef struct packed {
    logic [OP_W-1:0] x;
    logic [OP_W-1:0] y;
  } op_pair_t;

endpackage

// File: rtl/booth_op_fifo.sv
// Synchronous operand FIFO; pop_data shows the head combinationally.
// Latency: a push is visible at the head one cycle later.
// Backpressure: caller gates push on !full; push/pop in the same cycle keep count.
// Ports: clk, reset (sync, active-low), push/push_data, pop/pop_data,
//        full, empty, count.
module booth_op_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("booth_op_fifo: DEPTH must be a power of two >= 2");
  end

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage needs no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/booth_mul_issue.sv
// Issue/sequencer for the 32x32 Booth multiplier: queue operands, start one multiply, return tagged product.
// Latency: push at T -> pop at T+1, mul_start during T+1..T+2, res_valid the cycle after mul_valid.
// Backpressure: in_ready = !full; result held on res_* until res_ready, which also stalls the next issue.
// Ports: in_* operand push (valid/ready), mul_* multiplier interface, res_* result (valid/ready), busy.
// Optional: define BOOTH_ISSUE_TIMEOUT_EN to add a WAIT watchdog and a sticky err output.
module booth_mul_issue
  import booth_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_x,
  input  logic [OP_W-1:0]   in_y,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              mul_start,
  output logic [OP_W-1:0]   mul_x,
  output logic [OP_W-1:0]   mul_y,
  input  logic [PROD_W-1:0] mul_result,
  input  logic              mul_valid,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [PROD_W-1:0] res_data,
  output logic [TAG_W-1:0]  res_tag,
  output logic              busy
`ifdef BOOTH_ISSUE_TIMEOUT_EN
  ,
  output logic              err
`endif
);

  localparam int ENTRY_W = TAG_W + $bits(op_pair_t);

  if (TIMEOUT < 1) begin : g_timeout_chk
    $error("booth_mul_issue: TIMEOUT must be >= 1");
  end

  state_t                 state;
  logic [TAG_W-1:0]       op_tag;
  op_pair_t               in_pair;
  op_pair_t               head_pair;
  logic [TAG_W-1:0]       head_tag;
  logic [ENTRY_W-1:0]     fifo_rd;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   pop;

  assign in_pair               = '{x: in_x, y: in_y};
  assign {head_tag, head_pair} = fifo_rd;

  // in_ready ignores a same-cycle pop so it never combinationally depends on res_ready.
  assign in_ready = !fifo_full;

  // Pop from IDLE, or straight out of OUT on the accepting edge to avoid an IDLE bubble.
  assign pop = !fifo_empty &&
               ((state == S_IDLE) || ((state == S_OUT) && res_ready));

  // Pure decodes of the state register, so each is clean and mul_start can't repeat.
  assign mul_start = (state == S_ISSUE);
  assign res_valid = (state == S_OUT);
  assign busy      = (state != S_IDLE) || (fifo_count != '0);

  booth_op_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (in_valid && in_ready),
    .push_data ({in_tag, in_pair}),
    .pop       (pop),
    .pop_data  (fifo_rd),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

`ifdef BOOTH_ISSUE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_cnt;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      mul_x    <= '0;
      mul_y    <= '0;
      op_tag   <= '0;
      res_data <= '0;
      res_tag  <= '0;
`ifdef BOOTH_ISSUE_TIMEOUT_EN
      wait_cnt <= '0;
      err      <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (!fifo_empty) state <= S_ISSUE;
        end
        S_ISSUE: begin
          state <= S_WAIT;
`ifdef BOOTH_ISSUE_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        S_WAIT: begin
          // mul_valid is a one-cycle pulse; outside WAIT it is simply not looked at.
          if (mul_valid) begin
            res_data <= mul_result;
            res_tag  <= op_tag;
            state    <= S_OUT;
          end
`ifdef BOOTH_ISSUE_TIMEOUT_EN
          else if (wait_cnt == TW'(TIMEOUT - 1)) begin
            // Watchdog: return a zero product under the original tag and flag it.
            res_data <= '0;
            res_tag  <= op_tag;
            err      <= 1'b1;
            state    <= S_OUT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        S_OUT: begin
          if (res_ready) state <= fifo_empty ? S_IDLE : S_ISSUE;
        end
        default: state <= S_IDLE;
      endcase

      // Operands only change on a pop, so they hold from ISSUE through capture.
      if (pop) begin
        mul_x  <= head_pair.x;
        mul_y  <= head_pair.y;
        op_tag <= head_tag;
      end
    end
  end

endmodule
